// File: rtl/qspi_psram_ctrl_if.sv
// Host-side request/response bundle for the QSPI PSRAM controller.
// Latency: none, wires only.
// Backpressure: host holds req_i until ack_o; ready_o shows the controller is idle.
// Ports: req_i/we_i/adr_i/size_i/wdat_i (host -> ctrl), rdat_o/ack_o/ready_o (ctrl -> host).
interface qspi_psram_ctrl_if;
   logic        req_i;
   logic        we_i;
   logic [23:0] adr_i;
   logic [1:0]  size_i;
   logic [31:0] wdat_i;
   logic [31:0] rdat_o;
   logic        ack_o;
   logic        ready_o;

   modport master (
      output req_i, we_i, adr_i, size_i, wdat_i,
      input  rdat_o, ack_o, ready_o
   );

   modport slave (
      input  req_i, we_i, adr_i, size_i, wdat_i,
      output rdat_o, ack_o, ready_o
   );
endinterface

// File: rtl/qspi_psram_ctrl.sv
// QSPI PSRAM controller: quad-mode unlock after reset, then 1-4 byte reads (EB) / writes (38).
// Latency: accept -> ack_o is 2*(8+6+DUMMY_CYCLES+2N) clk for reads, 2*(8+6+2N) for writes.
// Backpressure: a request is only taken in IDLE; req_i held elsewhere simply waits.
// Ports: clk_i/rst_in, host bus (slave modport), sck_o/cs_no/io_o/io_oe_o out, io_i in.
module qspi_psram_ctrl #(
   parameter int DUMMY_CYCLES = 6
) (
   input  logic                    clk_i,
   input  logic                    rst_in,
   qspi_psram_ctrl_if.slave        bus,
   output logic                    sck_o,
   output logic                    cs_no,
   output logic [3:0]              io_o,
   output logic [3:0]              io_oe_o,
   input  logic [3:0]              io_i
);
   localparam logic [3:0] ST_UNLOCK       = 4'd0;
   localparam logic [3:0] ST_UNLOCK_DESEL = 4'd1;
   localparam logic [3:0] ST_IDLE         = 4'd2;
   localparam logic [3:0] ST_CMD          = 4'd3;
   localparam logic [3:0] ST_ADR          = 4'd4;
   localparam logic [3:0] ST_DUMMY        = 4'd5;
   localparam logic [3:0] ST_WDATA        = 4'd6;
   localparam logic [3:0] ST_RDATA        = 4'd7;
   localparam logic [3:0] ST_DESEL        = 4'd8;

   localparam logic [7:0] UNLOCK_CMD = 8'h35;
   localparam logic [7:0] DUMMY_LAST = 8'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

   logic [3:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;      // sck cycle index within the current state
   logic        start_q, start_d;  // first edge after reset launches the unlock
   logic        sck_q, sck_d;
   logic        cs_n_q, cs_n_d;
   logic [3:0]  io_q, io_d;
   logic [3:0]  oe_q, oe_d;
   logic        ack_q, ack_d;
   logic        we_q, we_d;
   logic [23:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [2:0]  nlast_q, nlast_d;  // index of the last data nibble (2N-1)
   logic [31:0] rbuf_q, rbuf_d;    // read assembly, copied to rdat only at completion
   logic [31:0] rdat_q, rdat_d;

   logic        new_cyc;           // this edge starts a new sck cycle (sck low half)
   logic [7:0]  cmd_byte;
   logic [23:0] adr_sh;
   logic [31:0] wdat_sh;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      start_d  = start_q;
      sck_d    = sck_q;
      cs_n_d   = cs_n_q;
      io_d     = io_q;
      oe_d     = oe_q;
      ack_d    = 1'b0;
      we_d     = we_q;
      adr_d    = adr_q;
      wdat_d   = wdat_q;
      nlast_d  = nlast_q;
      rbuf_d   = rbuf_q;
      rdat_d   = rdat_q;
      new_cyc  = 1'b0;
      cmd_byte = 8'h00;
      adr_sh   = 24'h0;
      wdat_sh  = 32'h0;

      if (start_q) begin
         start_d = 1'b0;
         new_cyc = 1'b1;
      end else if (state_q == ST_IDLE) begin
         if (bus.req_i) begin
            we_d    = bus.we_i;
            adr_d   = bus.adr_i;
            wdat_d  = bus.wdat_i;
            nlast_d = (bus.size_i == 2'd0) ? 3'd1 : (bus.size_i == 2'd1) ? 3'd3 : 3'd7;
            rbuf_d  = 32'h0;
            state_d = ST_CMD;
            cnt_d   = 8'd0;
            new_cyc = 1'b1;
         end
      end else if (!sck_q) begin
         // rising sck edge: the device data has been stable for a full clk
         sck_d = 1'b1;
         if (state_q == ST_RDATA) begin
            rbuf_d[{cnt_q[2:1], ~cnt_q[0], 2'b00} +: 4] = io_i;
         end
      end else begin
         sck_d = 1'b0;
         new_cyc = 1'b1;
         cnt_d = cnt_q + 8'd1;
         case (state_q)
            ST_UNLOCK:       if (cnt_q == 8'd7) begin state_d = ST_UNLOCK_DESEL; cnt_d = 8'd0; end
            ST_UNLOCK_DESEL: if (cnt_q == 8'd1) begin state_d = ST_IDLE; cnt_d = 8'd0; end
            ST_CMD:          if (cnt_q == 8'd7) begin state_d = ST_ADR; cnt_d = 8'd0; end
            ST_ADR: begin
               if (cnt_q == 8'd5) begin
                  cnt_d = 8'd0;
                  if (we_q)                   state_d = ST_WDATA;
                  else if (DUMMY_CYCLES == 0) state_d = ST_RDATA;
                  else                        state_d = ST_DUMMY;
               end
            end
            ST_DUMMY:        if (cnt_q == DUMMY_LAST) begin state_d = ST_RDATA; cnt_d = 8'd0; end
            ST_WDATA, ST_RDATA: begin
               if (cnt_q == {5'd0, nlast_q}) begin
                  state_d = ST_DESEL;
                  cnt_d   = 8'd0;
                  ack_d   = 1'b1;
                  if (state_q == ST_RDATA) rdat_d = rbuf_q;
               end
            end
            ST_DESEL:        if (cnt_q == 8'd1) begin state_d = ST_IDLE; cnt_d = 8'd0; end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end
         endcase
      end

      // Pin values for the sck cycle that begins on this edge.
      if (new_cyc) begin
         sck_d  = 1'b0;
         cs_n_d = 1'b1;
         io_d   = 4'h0;
         oe_d   = 4'h0;
         cmd_byte = we_d ? 8'h38 : 8'hEB;
         adr_sh   = adr_d >> (5'd20 - {cnt_d[2:0], 2'b00});
         wdat_sh  = wdat_d >> {cnt_d[2:1], ~cnt_d[0], 2'b00};
         case (state_d)
            ST_UNLOCK: begin
               cs_n_d = 1'b0;
               oe_d   = 4'b0001;
               io_d   = {3'b000, UNLOCK_CMD[3'd7 - cnt_d[2:0]]};
            end
            ST_CMD: begin
               cs_n_d = 1'b0;
               oe_d   = 4'b0001;
               io_d   = {3'b000, cmd_byte[3'd7 - cnt_d[2:0]]};
            end
            ST_ADR: begin
               cs_n_d = 1'b0;
               oe_d   = 4'hF;
               io_d   = adr_sh[3:0];
            end
            ST_WDATA: begin
               cs_n_d = 1'b0;
               oe_d   = 4'hF;
               io_d   = wdat_sh[3:0];
            end
            ST_DUMMY, ST_RDATA: cs_n_d = 1'b0;
            default: cs_n_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= ST_UNLOCK;
         cnt_q   <= 8'd0;
         start_q <= 1'b1;
         sck_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         io_q    <= 4'h0;
         oe_q    <= 4'h0;
         ack_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= 24'h0;
         wdat_q  <= 32'h0;
         nlast_q <= 3'd0;
         rbuf_q  <= 32'h0;
         rdat_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         sck_q   <= sck_d;
         cs_n_q  <= cs_n_d;
         io_q    <= io_d;
         oe_q    <= oe_d;
         ack_q   <= ack_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         nlast_q <= nlast_d;
         rbuf_q  <= rbuf_d;
         rdat_q  <= rdat_d;
      end
   end

   assign sck_o       = sck_q;
   assign cs_no       = cs_n_q;
   assign io_o        = io_q;
   assign io_oe_o     = oe_q;
   assign bus.ack_o   = ack_q;
   assign bus.rdat_o  = rdat_q;
   assign bus.ready_o = (state_q == ST_IDLE);
endmodule
